aes_decryption: RTL and testbench
=================================

# aes_decryption

Iterative AES-128 decryption core, the receive-side counterpart of the byte-serial AES encryption top. The core accepts a 128-bit cipher key and a 128-bit ciphertext block as 16 byte pairs, MSB byte first. It derives round key 10 on-chip, runs the FIPS-197 inverse cipher at one round per cycle, then emits the plaintext one byte at a time under a valid/ready handshake. It reuses the existing forward `subByte` S-box (32-bit) for the key schedule and a companion combinational `inv_sub_byte` (32-bit in/out, same shape) for InvSubBytes.

## Interface
- No parameters (AES-128 only).
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  key_byte/cipher_byte pair present.
- key_byte  in  8  cipher key byte.
- cipher_byte  in  8  ciphertext byte.
- in_ready  out  1  core accepts a byte pair this cycle.
- busy  out  1  high in KEXP, ROUND and UNLOAD.
- out_valid  out  1  plain_byte is valid.
- plain_byte  out  8  plaintext byte.
- out_ready  in  1  sink accepts plain_byte.

## Operation
- FSM states: IDLE, LOAD, KEXP, ROUND, UNLOAD.
- IDLE/LOAD
  - in_ready=1.
  - A handshake (in_valid&&in_ready) shifts key_byte into key_reg and cipher_byte into state_reg from the LSB end. The first byte accepted ends up in bits [127:120].
  - A 4-bit byte counter counts accepted pairs. The first handshake moves IDLE to LOAD.
  - The 16th handshake moves the FSM to KEXP and clears the counter.
  - in_valid with in_ready=0 is ignored; no data is captured.
- KEXP: 10 cycles, rcon index c=1..10.
  - Each cycle: key_reg <= forward next key (RotWord, SubWord, Rcon[c], XOR chain).
  - After 10 cycles key_reg = K10. Then go to ROUND with r=10.
- ROUND: 11 cycles, r=10 down to 0.
  - r=10: state <= state ^ K10.
  - r=9..1: state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ key_reg).
  - r=0: state <= InvSubBytes(InvShiftRows(state)) ^ key_reg. Then go to UNLOAD.
  - Key update on every ROUND cycle r≥1, producing K(r-1) from K(r)=w0..w3:
    - w3' = w3^w2, w2' = w2^w1, w1' = w1^w0.
    - w0' = w0 ^ SubWord(RotWord(w3')) ^ Rcon[r].
- Rcon sequence: 01,02,04,08,10,20,40,80,1b,36.
- UNLOAD
  - out_valid=1 and plain_byte=state[127:120].
  - On out_valid&&out_ready: state shifts left by 8 and the counter increments.
  - On the 16th handshake: go to IDLE, out_valid=0.
  - plain_byte and state hold while out_ready=0.
- Word and byte order follow FIPS-197: w0=[127:96]; column-major state, byte0=[127:120].
- All GF(2^8) arithmetic is mod x^8+x^4+x^3+x+1. InvMixColumns uses coefficients 0e,0b,0d,09.

## Timing
- Reset values: in_ready=0 during the rst cycle, 1 after it; busy=0; out_valid=0; plain_byte=8'h00. key_reg, state_reg and counters are zeroed. FSM=IDLE.
- Edge T accepts the 16th pair.
  - KEXP occupies edges T+1..T+10.
  - ROUND occupies edges T+11..T+21.
  - out_valid rises after edge T+21: latency 21 edges.
- Unload takes a minimum of 16 cycles. After the final output handshake edge, in_ready=1 the following cycle, so back-to-back blocks are allowed.
- in_ready is combinational from the FSM state only; it never depends on in_valid.
- rst asserted in any state, including mid-LOAD, mid-ROUND or mid-UNLOAD: the next cycle shows reset values. The partial block is discarded and no stale byte is emitted.
- The counter wraps 15→0 only on a state transition; it is never observed beyond 15.
- Simultaneous in_valid during UNLOAD is ignored. The input is not buffered.

## Test plan
- FIPS-197 C.1, back-to-back input.
  - Stimulus: key 000102030405060708090a0b0c0d0e0f, cipher 69c4e0d86a7b0430d8cdb78070b4c55a.
  - Required: plaintext 00112233445566778899aabbccddeeff, MSB first; out_valid exactly 21 edges after the 16th accept; key_reg=13111d7fe3944a17f307a78b4d2b30c5 at KEXP exit.
- FIPS-197 B, in_valid asserted every other cycle.
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, cipher 3925841d02dc09fbdc118597196a0b32.
  - Required: plaintext 3243f6a8885a308d313198a2e0370734; K10=d014f9a8c9ee2589e13f0cc8b6630ca6.
- Backpressure.
  - Stimulus: all-zero key, cipher 66e94bd4ef8a2c3b884cfa59ca342b2e, out_ready random ~40%.
  - Required: plain_byte stable while stalled; exactly 16 bytes 00; return to IDLE.
- Reset mid-ROUND (r=5).
  - Required: next cycle out_valid=0, busy=0, in_ready=1, plain_byte=00. Reloading the C.1 vector yields the correct plaintext.
- in_valid held high throughout two consecutive blocks (C.1 then B).
  - Required: bytes offered during busy are ignored; both plaintexts are correct and in order.

Source files
------------

// File: rtl/aes_decryption.sv
// ---------------------------------------------------------------------------
// aes_decryption -- iterative AES-128 inverse cipher, byte-serial I/O.
//
// Purpose: takes a cipher key and a ciphertext block as 16 byte pairs
// (MSB byte first), derives round key 10 on-chip (10 cycles), runs the
// inverse cipher at one round per cycle (11 cycles), then streams the
// plaintext out one byte per valid/ready handshake.
//
// Ports:
//   clk          in   clock
//   rst          in   synchronous active-high reset
//   in_valid     in   key_byte/cipher_byte pair present
//   key_byte     in   [7:0] cipher key byte
//   cipher_byte  in   [7:0] ciphertext byte
//   in_ready     out  core accepts a pair this cycle (IDLE/LOAD)
//   busy         out  high in KEXP, ROUND and UNLOAD
//   out_valid    out  plain_byte is valid
//   plain_byte   out  [7:0] plaintext byte
//   out_ready    in   sink accepts plain_byte
//
// Also contains the shared GF(2^8) package, the forward subByte S-box
// (key schedule) and inv_sub_byte (InvSubBytes). Both S-boxes are
// computed from the field inverse and the affine map rather than tables.
// ---------------------------------------------------------------------------

package aes_dec_pkg;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 == a^-1 for a != 0, and maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = a;
    acc = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] v;
    case (idx)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

endpackage

// Forward S-box on a 32-bit word: affine(inverse(b)).
module subByte (
  input  logic [31:0] i_word,
  output logic [31:0] o_word
);
  import aes_dec_pkg::*;
  for (genvar gi = 0; gi < 4; gi++) begin : g_byte
    logic [7:0] w_inv;
    assign w_inv = gf_inv(i_word[8*gi +: 8]);
    assign o_word[8*gi +: 8] = w_inv ^ rotl8(w_inv, 1) ^ rotl8(w_inv, 2)
                             ^ rotl8(w_inv, 3) ^ rotl8(w_inv, 4) ^ 8'h63;
  end
endmodule

// Inverse S-box on a 32-bit word: inverse(inv_affine(b)).
module inv_sub_byte (
  input  logic [31:0] i_word,
  output logic [31:0] o_word
);
  import aes_dec_pkg::*;
  for (genvar gi = 0; gi < 4; gi++) begin : g_byte
    logic [7:0] w_pre;
    assign w_pre = rotl8(i_word[8*gi +: 8], 1) ^ rotl8(i_word[8*gi +: 8], 3)
                 ^ rotl8(i_word[8*gi +: 8], 6) ^ 8'h05;
    assign o_word[8*gi +: 8] = gf_inv(w_pre);
  end
endmodule

module aes_decryption (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] key_byte,
  input  logic [7:0] cipher_byte,
  output logic       in_ready,
  output logic       busy,
  output logic       out_valid,
  output logic [7:0] plain_byte,
  input  logic       out_ready
);
  import aes_dec_pkg::*;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_KEXP, S_ROUND, S_UNLOAD} fsm_t;

  fsm_t         r_fsm;
  fsm_t         w_fsm_next;
  logic [3:0]   r_cnt;      // byte counter for LOAD and UNLOAD
  logic [3:0]   r_rnd;      // rcon index in KEXP, round number in ROUND
  logic [127:0] r_key;
  logic [127:0] r_state;

  logic         w_in_fire;
  logic         w_out_fire;

  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = out_valid && out_ready;

  // ---------------- key schedule (forward in KEXP, reverse in ROUND) -----
  logic [31:0]  w_k0, w_k1, w_k2, w_k3;
  logic [31:0]  w_sb_in, w_sb_out, w_rcon_word;
  logic [127:0] w_key_fwd, w_key_inv;

  assign {w_k0, w_k1, w_k2, w_k3} = r_key;
  // Walking backwards, the word that fed SubWord is the recovered w3'.
  assign w_sb_in     = (r_fsm == S_ROUND) ? (w_k3 ^ w_k2) : w_k3;
  assign w_rcon_word = {rcon(r_rnd), 24'h000000};

  subByte u_key_sbox (
    .i_word ({w_sb_in[23:0], w_sb_in[31:24]}),
    .o_word (w_sb_out)
  );

  logic [31:0] w_f0, w_f1, w_f2, w_f3;
  assign w_f0 = w_k0 ^ w_sb_out ^ w_rcon_word;
  assign w_f1 = w_k1 ^ w_f0;
  assign w_f2 = w_k2 ^ w_f1;
  assign w_f3 = w_k3 ^ w_f2;
  assign w_key_fwd = {w_f0, w_f1, w_f2, w_f3};
  assign w_key_inv = {w_k0 ^ w_sb_out ^ w_rcon_word, w_k1 ^ w_k0,
                      w_k2 ^ w_k1, w_k3 ^ w_k2};

  // ---------------- round datapath ---------------------------------------
  logic [127:0] w_isr, w_isb, w_ark, w_imc;

  // InvShiftRows: row r of column c takes row r of column (c - r) mod 4.
  for (genvar gi = 0; gi < 4; gi++) begin : g_isr_col
    for (genvar gj = 0; gj < 4; gj++) begin : g_isr_row
      assign w_isr[127 - 8*(4*gi + gj) -: 8] =
        r_state[127 - 8*(4*((gi - gj + 4) % 4) + gj) -: 8];
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_isb
    inv_sub_byte u_inv_sbox (
      .i_word (w_isr[127 - 32*gi -: 32]),
      .o_word (w_isb[127 - 32*gi -: 32])
    );
  end

  assign w_ark = w_isb ^ r_key;

  for (genvar gi = 0; gi < 4; gi++) begin : g_imc
    logic [7:0] w_a0, w_a1, w_a2, w_a3;
    assign {w_a0, w_a1, w_a2, w_a3} = w_ark[127 - 32*gi -: 32];
    assign w_imc[127 - 32*gi -: 8] = gf_mul(8'h0e, w_a0) ^ gf_mul(8'h0b, w_a1)
                                   ^ gf_mul(8'h0d, w_a2) ^ gf_mul(8'h09, w_a3);
    assign w_imc[119 - 32*gi -: 8] = gf_mul(8'h09, w_a0) ^ gf_mul(8'h0e, w_a1)
                                   ^ gf_mul(8'h0b, w_a2) ^ gf_mul(8'h0d, w_a3);
    assign w_imc[111 - 32*gi -: 8] = gf_mul(8'h0d, w_a0) ^ gf_mul(8'h09, w_a1)
                                   ^ gf_mul(8'h0e, w_a2) ^ gf_mul(8'h0b, w_a3);
    assign w_imc[103 - 32*gi -: 8] = gf_mul(8'h0b, w_a0) ^ gf_mul(8'h0d, w_a1)
                                   ^ gf_mul(8'h09, w_a2) ^ gf_mul(8'h0e, w_a3);
  end

  // ---------------- FSM: state register -----------------------------------
  always_ff @(posedge clk) begin
    if (rst) r_fsm <= S_IDLE;
    else     r_fsm <= w_fsm_next;
  end

  // ---------------- FSM: next state ---------------------------------------
  always_comb begin
    w_fsm_next = r_fsm;
    case (r_fsm)
      S_IDLE:   if (w_in_fire) w_fsm_next = (r_cnt == 4'd15) ? S_KEXP : S_LOAD;
      S_LOAD:   if (w_in_fire && r_cnt == 4'd15) w_fsm_next = S_KEXP;
      S_KEXP:   if (r_rnd == 4'd10) w_fsm_next = S_ROUND;
      S_ROUND:  if (r_rnd == 4'd0) w_fsm_next = S_UNLOAD;
      S_UNLOAD: if (w_out_fire && r_cnt == 4'd15) w_fsm_next = S_IDLE;
      default:  w_fsm_next = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ------------------------------------------
  always_comb begin
    in_ready   = !rst && (r_fsm == S_IDLE || r_fsm == S_LOAD);
    busy       = (r_fsm == S_KEXP) || (r_fsm == S_ROUND) || (r_fsm == S_UNLOAD);
    out_valid  = (r_fsm == S_UNLOAD);
    plain_byte = (r_fsm == S_UNLOAD) ? r_state[127:120] : 8'h00;
  end

  // ---------------- datapath registers ------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= 4'd0;
      r_rnd   <= 4'd0;
      r_key   <= '0;
      r_state <= '0;
    end else begin
      case (r_fsm)
        S_IDLE, S_LOAD: begin
          if (w_in_fire) begin
            r_key   <= {r_key[119:0], key_byte};
            r_state <= {r_state[119:0], cipher_byte};
            r_cnt   <= r_cnt + 4'd1;   // 15 -> 0 coincides with entering KEXP
            if (r_cnt == 4'd15) r_rnd <= 4'd1;
          end
        end
        S_KEXP: begin
          r_key <= w_key_fwd;
          // Leaving KEXP after rcon 10 hands r_rnd = 10 straight to ROUND.
          if (r_rnd != 4'd10) r_rnd <= r_rnd + 4'd1;
        end
        S_ROUND: begin
          case (r_rnd)
            4'd10:   r_state <= r_state ^ r_key;
            4'd0:    r_state <= w_ark;
            default: r_state <= w_imc;
          endcase
          if (r_rnd != 4'd0) begin
            r_key <= w_key_inv;
            r_rnd <= r_rnd - 4'd1;
          end
        end
        S_UNLOAD: begin
          if (w_out_fire) begin
            r_state <= {r_state[119:0], 8'h00};
            r_cnt   <= r_cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_decryption.sv
// ---------------------------------------------------------------------------
// tb_aes_decryption -- directed bench for aes_decryption using the FIPS-197
// vectors (C.1, B, all-zero key), backpressure, mid-round reset and
// in_valid held high across two blocks.
// ---------------------------------------------------------------------------
module tb_aes_decryption;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] key_byte;
  logic [7:0] cipher_byte;
  logic       in_ready;
  logic       busy;
  logic       out_valid;
  logic [7:0] plain_byte;
  logic       out_ready;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_K10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_K10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] Z_K10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  aes_decryption dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .key_byte    (key_byte),
    .cipher_byte (cipher_byte),
    .in_ready    (in_ready),
    .busy        (busy),
    .out_valid   (out_valid),
    .plain_byte  (plain_byte),
    .out_ready   (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present 16 pairs; optional idle cycle between pairs; optionally leave
  // in_valid high afterwards with junk bytes while the core is busy.
  task automatic send_block(input logic [127:0] key, input logic [127:0] ct,
                            input bit gap, input bit hold);
    int guard;
    for (int i = 0; i < 16; i++) begin
      in_valid    = 1'b1;
      key_byte    = key[127 - 8*i -: 8];
      cipher_byte = ct[127 - 8*i -: 8];
      guard = 0;
      while (!in_ready && guard < 100) begin
        @(posedge clk); #1;
        guard++;
      end
      if (!in_ready) check("send_timeout", 128'(in_ready), 128'd1);
      @(posedge clk); #1;
      if (gap && i < 15) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    if (hold) begin
      in_valid    = 1'b1;
      key_byte    = 8'ha5;
      cipher_byte = 8'h5a;
    end else begin
      in_valid = 1'b0;
    end
  endtask

  task automatic recv_block(input bit rnd, output logic [127:0] pt);
    int n = 0;
    int guard = 0;
    bit stalled = 1'b0;
    logic [7:0] held = 8'h00;
    pt = '0;
    while (n < 16 && guard < 400) begin
      out_ready = rnd ? ($urandom_range(0, 99) < 40) : 1'b1;
      if (stalled) begin
        check("stall_hold", 128'(plain_byte), 128'(held));
        stalled = 1'b0;
      end
      if (out_valid && out_ready) begin
        pt = {pt[119:0], plain_byte};
        n++;
      end else if (out_valid) begin
        held    = plain_byte;
        stalled = 1'b1;
      end
      @(posedge clk); #1;
      guard++;
    end
    out_ready = 1'b0;
    if (n < 16) check("recv_timeout", 128'(n), 128'd16);
  endtask

  task automatic run_block(input string tag, input logic [127:0] key, input logic [127:0] ct,
                           input bit gap, input bit rnd, input bit hold,
                           input logic [127:0] exp_pt, input logic [127:0] exp_k10);
    int t_acc;
    int guard;
    logic [127:0] pt;
    send_block(key, ct, gap, hold);
    t_acc = cyc;
    repeat (10) begin
      @(posedge clk); #1;
    end
    check({tag, "_k10"}, dut.r_key, exp_k10);
    check({tag, "_busy"}, 128'(busy), 128'd1);
    guard = 0;
    while (!out_valid && guard < 40) begin
      @(posedge clk); #1;
      guard++;
    end
    check({tag, "_latency"}, 128'(cyc - t_acc), 128'd21);
    recv_block(rnd, pt);
    check({tag, "_plain"}, pt, exp_pt);
    check({tag, "_done_out_valid"}, 128'(out_valid), 128'd0);
    check({tag, "_done_busy"}, 128'(busy), 128'd0);
    check({tag, "_done_in_ready"}, 128'(in_ready), 128'd1);
    $display("block %s key=%h ct=%h pt=%h", tag, key, ct, pt);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    key_byte = 8'h00;
    cipher_byte = 8'h00;
    out_ready = 1'b0;

    // Reset values.
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_in_ready", 128'(in_ready), 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_plain_byte", 128'(plain_byte), 128'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 128'(in_ready), 128'd1);

    run_block("c1", C1_KEY, C1_CT, 1'b0, 1'b0, 1'b0, C1_PT, C1_K10);
    run_block("fips_b_gap", B_KEY, B_CT, 1'b1, 1'b0, 1'b0, B_PT, B_K10);
    run_block("zero_bp", 128'h0, Z_CT, 1'b0, 1'b1, 1'b0, 128'h0, Z_K10);

    // Reset while ROUND is at r=5 (edge T+16), then reload C.1.
    send_block(C1_KEY, C1_CT, 1'b0, 1'b0);
    repeat (15) begin
      @(posedge clk); #1;
    end
    check("mid_round_busy", 128'(busy), 128'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_out_valid", 128'(out_valid), 128'd0);
    check("mid_rst_busy", 128'(busy), 128'd0);
    check("mid_rst_plain_byte", 128'(plain_byte), 128'd0);
    rst = 1'b0;
    #1;
    check("mid_rst_in_ready", 128'(in_ready), 128'd1);
    run_block("c1_after_rst", C1_KEY, C1_CT, 1'b0, 1'b0, 1'b0, C1_PT, C1_K10);

    // in_valid held high across two consecutive blocks.
    run_block("hold_c1", C1_KEY, C1_CT, 1'b0, 1'b0, 1'b1, C1_PT, C1_K10);
    run_block("hold_b", B_KEY, B_CT, 1'b0, 1'b0, 1'b1, B_PT, B_K10);
    in_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
